// File: rtl/hilo_file_if.sv
// HI/LO unit bus: EX-stage requests, divider result and the HI/LO read/stall responses.
interface hilo_file_if #(parameter int DATA_W = 32);
  logic                  flush_i;
  logic [2:0]            op_i;
  logic [DATA_W-1:0]     src_i;
  logic [2*DATA_W-1:0]   mul_i;
  logic                  div_done_i;
  logic [2*DATA_W-1:0]   div_res_i;
  logic                  rd_i;
  logic [DATA_W-1:0]     hi_o;
  logic [DATA_W-1:0]     lo_o;
  logic                  busy_o;
  logic                  stall_o;

  modport master (
    output flush_i, op_i, src_i, mul_i, div_done_i, div_res_i, rd_i,
    input  hi_o, lo_o, busy_o, stall_o
  );

  modport slave (
    input  flush_i, op_i, src_i, mul_i, div_done_i, div_res_i, rd_i,
    output hi_o, lo_o, busy_o, stall_o
  );
endinterface

// File: rtl/hilo_file.sv
// HI/LO special-register unit with multiply-accumulate and an outstanding-divide tracker.
// Optional macro HILO_FWD_EN: hi_o/lo_o bypass the value being written this cycle.
module hilo_file #(
  parameter int DATA_W    = 32,
  parameter bit FLUSH_DIV = 1'b1
) (
  input logic       clk,
  input logic       rst,
  hilo_file_if.slave bus
);
  localparam int W2 = 2 * DATA_W;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MTHI = 3'd1,
    OP_MTLO = 3'd2,
    OP_MUL  = 3'd3,
    OP_MADD = 3'd4,
    OP_MSUB = 3'd5,
    OP_DIV  = 3'd6,
    OP_RSV  = 3'd7
  } op_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  op_t               w_op;
  logic              w_wait;
  logic              w_done;
  logic              w_stall;
  logic              w_op_en;
  logic              w_issue;
  logic [W2-1:0]     w_base;
  logic [W2-1:0]     w_nxt;

  always_comb begin
    w_op    = op_t'(bus.op_i);
    w_wait  = (r_state == S_WAIT);
    w_done  = w_wait & bus.div_done_i;
    w_stall = w_wait & ~bus.div_done_i & (bus.rd_i | (bus.op_i != 3'd0));
    w_op_en = ~bus.flush_i & ~w_stall;
    w_issue = w_op_en & (w_op == OP_DIV);
  end

  // A retiring divide lands first; a same-cycle op then acts on that result.
  always_comb begin
    w_base = w_done ? bus.div_res_i : {r_hi, r_lo};
    w_nxt  = w_base;
    if (w_op_en) begin
      case (w_op)
        OP_MTHI: w_nxt[W2-1:DATA_W] = bus.src_i;
        OP_MTLO: w_nxt[DATA_W-1:0]  = bus.src_i;
        OP_MUL:  w_nxt = bus.mul_i;
        OP_MADD: w_nxt = w_base + bus.mul_i;
        OP_MSUB: w_nxt = w_base - bus.mul_i;
        default: w_nxt = w_base;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      {r_hi, r_lo} <= w_nxt;
      case (r_state)
        S_IDLE: if (w_issue) r_state <= S_WAIT;
        S_WAIT: begin
          // A divide result always commits, even under flush.
          if (bus.div_done_i)             r_state <= w_issue ? S_WAIT : S_IDLE;
          else if (bus.flush_i && FLUSH_DIV) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o  = w_wait;
  assign bus.stall_o = w_stall;

`ifdef HILO_FWD_EN
  assign bus.hi_o = w_nxt[W2-1:DATA_W];
  assign bus.lo_o = w_nxt[DATA_W-1:0];
`else
  assign bus.hi_o = r_hi;
  assign bus.lo_o = r_lo;
`endif

  a_stall_busy: assert property (@(posedge clk) disable iff (rst) bus.stall_o |-> bus.busy_o);

endmodule

// File: tb/tb_hilo_file.sv
// Randomized bench for hilo_file against an arithmetic HI/LO + pending-divide model.
module tb_hilo_file;
  localparam int DW = 32;
  localparam bit FD = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_file_if #(.DATA_W(DW)) bus ();
  hilo_file #(.DATA_W(DW), .FLUSH_DIV(FD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  logic [2*DW-1:0] m_acc;   // {HI,LO} as one number
  bit              m_pend;  // a divide is outstanding

  logic [DW-1:0] ob_hi, ob_lo;
  logic          ob_stall, ob_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational outputs mid-cycle, advance the model at the edge.
  task automatic cyc(input bit r, input bit fl, input logic [2:0] op, input logic [DW-1:0] src,
                     input logic [2*DW-1:0] mul, input bit dn, input logic [2*DW-1:0] res,
                     input bit rd);
    bit done, stall, go, pend_n;
    logic [2*DW-1:0] base, nxt;
    rst = r; bus.flush_i = fl; bus.op_i = op; bus.src_i = src; bus.mul_i = mul;
    bus.div_done_i = dn; bus.div_res_i = res; bus.rd_i = rd;
    done  = m_pend && dn;
    stall = m_pend && !dn && (rd || op != 3'd0);
    go    = !fl && !stall;
    base  = done ? res : m_acc;
    nxt   = base;
    if (go) begin
      if (op == 3'd1) nxt = {src, base[DW-1:0]};
      if (op == 3'd2) nxt = {base[2*DW-1:DW], src};
      if (op == 3'd3) nxt = mul;
      if (op == 3'd4) nxt = base + mul;
      if (op == 3'd5) nxt = base - mul;
    end
    if (m_pend) pend_n = dn ? (go && op == 3'd6) : !(fl && FD);
    else        pend_n = go && op == 3'd6;
    #4;
    ob_hi = bus.hi_o; ob_lo = bus.lo_o; ob_stall = bus.stall_o; ob_busy = bus.busy_o;
    if (!r) begin
      chk("stall", ob_stall, stall);
      chk("busy", ob_busy, m_pend);
`ifdef HILO_FWD_EN
      chk("hi_fwd", ob_hi, nxt[2*DW-1:DW]);
      chk("lo_fwd", ob_lo, nxt[DW-1:0]);
`else
      chk("hi", ob_hi, m_acc[2*DW-1:DW]);
      chk("lo", ob_lo, m_acc[DW-1:0]);
`endif
    end
    @(posedge clk); #1;
    m_acc  = r ? '0 : nxt;
    m_pend = r ? 1'b0 : pend_n;
  endtask

  task automatic nop(input bit rd);
    cyc(0, 0, 3'd0, '0, '0, 0, '0, rd);
  endtask

  initial begin
    m_acc = '0; m_pend = 0;
    rst = 1; bus.flush_i = 0; bus.op_i = 0; bus.src_i = 0; bus.mul_i = 0;
    bus.div_done_i = 0; bus.div_res_i = 0; bus.rd_i = 0;
    @(posedge clk); #1;

    // reset overrides a MUL
    cyc(1, 0, 3'd3, '0, 64'h1_0000_0002, 0, '0, 0);
    nop(1);
    chk("rst_hi", ob_hi, 0); chk("rst_lo", ob_lo, 0); chk("rst_busy", ob_busy, 0);

    // carry across halves
    cyc(0, 0, 3'd3, '0, 64'h0000_0001_FFFF_FFFF, 0, '0, 0);
    cyc(0, 0, 3'd4, '0, 64'h1, 0, '0, 0);
    nop(1);
    chk("madd_hi", ob_hi, 32'd2); chk("madd_lo", ob_lo, 32'd0);

    // borrow wraps
    cyc(0, 0, 3'd3, '0, '0, 0, '0, 0);
    cyc(0, 0, 3'd5, '0, 64'h1, 0, '0, 0);
    nop(1);
    chk("msub_hi", ob_hi, 32'hFFFF_FFFF); chk("msub_lo", ob_lo, 32'hFFFF_FFFF);

    // divide with stalled reads
    cyc(0, 0, 3'd6, '0, '0, 0, '0, 0);
    nop(0); nop(0);
    for (int i = 0; i < 3; i++) begin
      nop(1);
      chk("div_stall", ob_stall, 1);
    end
    cyc(0, 0, 3'd0, '0, '0, 1, {32'h3, 32'h7}, 1);
    chk("div_done_stall", ob_stall, 0);
    nop(1);
    chk("div_hi", ob_hi, 32'h3); chk("div_lo", ob_lo, 32'h7); chk("div_busy", ob_busy, 0);

    // flushed divide is discarded
    cyc(0, 0, 3'd6, '0, '0, 0, '0, 0);
    cyc(0, 1, 3'd0, '0, '0, 0, '0, 0);
    nop(0);
    chk("flush_busy", ob_busy, 0);
    cyc(0, 0, 3'd0, '0, '0, 1, {32'h99, 32'h88}, 0);
    nop(1);
    chk("flush_hi", ob_hi, 32'h3); chk("flush_lo", ob_lo, 32'h7);

    // MTLO with same-cycle read
    cyc(0, 0, 3'd2, 32'hA5A5_A5A5, '0, 0, '0, 1);
`ifdef HILO_FWD_EN
    chk("mtlo_rd", ob_lo, 32'hA5A5_A5A5);
`else
    chk("mtlo_rd", ob_lo, 32'h7);
`endif

    // divide retiring under a same-cycle MADD
    cyc(0, 0, 3'd6, '0, '0, 0, '0, 0);
    cyc(0, 0, 3'd4, '0, 64'h10, 1, {32'h1, 32'h2}, 0);
    nop(1);
    chk("done_madd_hi", ob_hi, 32'h1); chk("done_madd_lo", ob_lo, 32'h12);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 97) == 0, ($urandom % 8) == 0, 3'($urandom % 8), $urandom,
          {$urandom, $urandom}, ($urandom % 4) == 0, {$urandom, $urandom}, ($urandom % 2) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
